pipe_ctrl: RTL

Pipeline sequencing controller for the 5-stage core. It issues per-stage stall and flush commands to the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB inter-stage registers. It resolves four conditions: load-use hazards, multi-cycle EX operations, taken branches and data-memory wait states. It contains a multi-cycle sequencer FSM with a cycle counter; all other decisions are combinational from FSM state and inputs.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl_hazard_detect.sv | 14 +
 rtl/pipe_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage bit indices, sequencer state enum and default multi-cycle counter width.
package pipe_pkg;
  localparam int STG_PC = 0;
  localparam int STG_IF_ID = 1;
  localparam int STG_ID_EX = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;
  localparam int MULTI_CNT_W = 6;
  typedef enum logic {RUN, MULTI} state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and stall/flush/perf outputs between the core (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(parameter int MULTI_CNT_W = pipe_pkg::MULTI_CNT_W) ();
  logic id_rs1_re;
  logic [4:0] id_rs1_addr;
  logic id_rs2_re;
  logic [4:0] id_rs2_addr;
  logic ex_rd_we;
  logic [4:0] ex_rd_addr;
  logic ex_is_load;
  logic ex_multi_req;
  logic [MULTI_CNT_W-1:0] ex_multi_cycles;
  logic ex_branch_taken;
  logic mem_busy;
  logic [4:0] stall;
  logic [4:0] flush;
  logic pc_sel;
  logic ex_done;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  modport master (
    output id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr, ex_rd_we, ex_rd_addr, ex_is_load,
           ex_multi_req, ex_multi_cycles, ex_branch_taken, mem_busy,
    input  stall, flush, pc_sel, ex_done, perf_stall_cnt, perf_flush_cnt
  );
  modport slave (
    input  id_rs1_re, id_rs1_addr, id_rs2_re, id_rs2_addr, ex_rd_we, ex_rd_addr, ex_is_load,
           ex_multi_req, ex_multi_cycles, ex_branch_taken, mem_busy,
    output stall, flush, pc_sel, ex_done, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose nonzero destination is read by the instruction in ID.
module hazard_detect (
  input  logic       ex_is_load,
  input  logic       ex_rd_we,
  input  logic [4:0] ex_rd_addr,
  input  logic       id_rs1_re,
  input  logic [4:0] id_rs1_addr,
  input  logic       id_rs2_re,
  input  logic [4:0] id_rs2_addr,
  output logic       load_use
);
  assign load_use = ex_is_load && ex_rd_we && ex_rd_addr != 5'd0 &&
                    ((id_rs1_re && id_rs1_addr == ex_rd_addr) || (id_rs2_re && id_rs2_addr == ex_rd_addr));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage stall/flush sequencer with a multi-cycle EX FSM; PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULTI_CNT_W = pipe_pkg::MULTI_CNT_W
) (
  input logic clk,
  input logic rst,
  pipe_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [MULTI_CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] stall, flush;
  logic pc_sel, ex_done, load_use;
  hazard_detect u_hazard (
    .ex_is_load (bus.ex_is_load),
    .ex_rd_we   (bus.ex_rd_we),
    .ex_rd_addr (bus.ex_rd_addr),
    .id_rs1_re  (bus.id_rs1_re),
    .id_rs1_addr(bus.id_rs1_addr),
    .id_rs2_re  (bus.id_rs2_re),
    .id_rs2_addr(bus.id_rs2_addr),
    .load_use   (load_use)
  );
  // Priority: rst, mem_busy, MULTI, branch, multi request, load-use.
  always_comb begin
    stall = '0;
    flush = '0;
    pc_sel = 1'b0;
    ex_done = 1'b0;
    state_d = state_q;
    cnt_d = cnt_q;
    if (rst) begin
      flush = 5'b11110;
    end else if (bus.mem_busy) begin
      stall = 5'b01111;
      flush[STG_MEM_WB] = 1'b1;
    end else if (state_q == MULTI) begin
      if (!bus.ex_multi_req) begin
        state_d = RUN;
        cnt_d = '0;
      end else if (cnt_q != '0) begin
        stall = 5'b00111;
        flush[STG_EX_MEM] = 1'b1;
        cnt_d = cnt_q - MULTI_CNT_W'(1);
      end else begin
        ex_done = 1'b1;
        state_d = RUN;
      end
    end else if (bus.ex_branch_taken) begin
      pc_sel = 1'b1;
      flush[STG_ID_EX] = 1'b1;
      flush[STG_IF_ID] = 1'b1;
    end else if (bus.ex_multi_req) begin
      if (bus.ex_multi_cycles >= MULTI_CNT_W'(2)) begin
        stall = 5'b00111;
        flush[STG_EX_MEM] = 1'b1;
        cnt_d = bus.ex_multi_cycles - MULTI_CNT_W'(2);
        state_d = MULTI;
      end else begin
        ex_done = 1'b1;
      end
    end else if (load_use) begin
      stall = 5'b00011;
      flush[STG_ID_EX] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.stall = stall;
  assign bus.flush = flush;
  assign bus.pc_sel = pc_sel;
  assign bus.ex_done = ex_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;
  always_comb begin
    perf_stall_d = perf_stall_q + 32'(stall[STG_PC]);
    perf_flush_d = perf_flush_q + 32'(pc_sel);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end
  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_flush_cnt = '0;
`endif
endmodule
